door_timer: RTL and testbench

Elevator door-open countdown timer with 100 ms resolution. It counts a fixed open interval down from OPEN_S.0 s to 0.0 s and reports seconds and tenths as BCD and as active-low 7-segment codes. Its `seg_s` and `seg_100ms` outputs drive the seconds and tenths digits of the multiplexed display scanner. A one-cycle `done` pulse tells the elevator controller to close the door.

---
 rtl/door_timer.sv | 104 ++++++++++
 tb/tb_door_timer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/door_timer.sv
// Elevator door-open countdown: OPEN_S.0 s down to 0.0 s in 100 ms ticks,
// with BCD and active-low 7-segment readouts and a one-cycle done pulse.
module door_timer #(
  parameter int TICK_DIV = 5_000_000,
  parameter int OPEN_S   = 5
) (
  input  logic       clk,
  input  logic       sysclr,
  input  logic       start,
  input  logic       hold,
  input  logic       cancel,
  output logic       busy,
  output logic       done,
  output logic [3:0] sec_bcd,
  output logic [3:0] tenth_bcd,
  output logic [6:0] seg_s,
  output logic [6:0] seg_100ms
);

  localparam int               PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [3:0]       OPEN_BCD = 4'(OPEN_S);
  localparam logic [6:0]       SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE
  } state_t;

  state_t           state;
  logic [PRE_W-1:0] pre;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or posedge sysclr) begin
    if (sysclr) begin
      state     <= S_IDLE;
      pre       <= '0;
      sec_bcd   <= 4'd0;
      tenth_bcd <= 4'd0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cancel) begin
        state     <= S_IDLE;
        pre       <= '0;
        sec_bcd   <= 4'd0;
        tenth_bcd <= 4'd0;
      end else if (start) begin
        state     <= hold ? S_PAUSE : S_RUN;
        pre       <= '0;
        sec_bcd   <= OPEN_BCD;
        tenth_bcd <= 4'd0;
      end else if (state != S_IDLE) begin
        if (hold) begin
          state <= S_PAUSE;
        end else begin
          // Leaving PAUSE counts on the same edge, so each PAUSE cycle costs
          // exactly one cycle of delay.
          state <= S_RUN;
          if (pre == PRE_LAST) begin
            pre <= '0;
            if (tenth_bcd != 4'd0) begin
              tenth_bcd <= tenth_bcd - 4'd1;
            end else begin
              tenth_bcd <= 4'd9;
              sec_bcd   <= sec_bcd - 4'd1;
            end
            if (sec_bcd == 4'd0 && tenth_bcd == 4'd1) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
          end else begin
            pre <= pre + PRE_W'(1);
          end
        end
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    busy      = (state != S_IDLE);
    seg_s     = busy ? seg7(sec_bcd)   : SEG_BLANK;
    seg_100ms = busy ? seg7(tenth_bcd) : SEG_BLANK;
  end

endmodule

// File: tb/tb_door_timer.sv
// Scoreboard bench for door_timer (TICK_DIV=4, OPEN_S=2): a tenths-remaining
// model pushes expected outputs per edge; they are popped after the edge.
module tb_door_timer;

  localparam int TD = 4;
  localparam int OS = 2;

  logic       clk = 1'b0;
  logic       sysclr, start, hold, cancel;
  logic       busy, done;
  logic [3:0] sec_bcd, tenth_bcd;
  logic [6:0] seg_s, seg_100ms;

  door_timer #(.TICK_DIV(TD), .OPEN_S(OS)) dut (
    .clk(clk), .sysclr(sysclr), .start(start), .hold(hold), .cancel(cancel),
    .busy(busy), .done(done), .sec_bcd(sec_bcd), .tenth_bcd(tenth_bcd),
    .seg_s(seg_s), .seg_100ms(seg_100ms)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: remaining time kept as an integer count of tenths.
  bit m_busy, m_done;
  int m_rem, m_pre;
  logic [31:0] sb[$];

  function automatic logic [6:0] pat(input int d);
    logic [6:0] t[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return t[d];
  endfunction

  function automatic logic [31:0] model_out();
    logic [6:0] ss, st;
    ss = m_busy ? pat(m_rem / 10) : 7'h7F;
    st = m_busy ? pat(m_rem % 10) : 7'h7F;
    return {6'd0, m_busy, m_done, 4'(m_rem / 10), 4'(m_rem % 10), 1'b0, ss, 1'b0, st};
  endfunction

  function automatic logic [31:0] dut_out();
    return {6'd0, busy, done, sec_bcd, tenth_bcd, 1'b0, seg_s, 1'b0, seg_100ms};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_rem = 0; m_pre = 0;
  endtask

  task automatic model_edge(input bit s, input bit h, input bit c);
    m_done = 0;
    if (c) begin
      m_busy = 0; m_rem = 0; m_pre = 0;
    end else if (s) begin
      m_busy = 1; m_rem = 10 * OS; m_pre = 0;
    end else if (m_busy && !h) begin
      if (m_pre == TD - 1) begin
        m_pre = 0;
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 0; m_done = 1;
        end
      end else begin
        m_pre++;
      end
    end
  endtask

  int edge_n = 0;
  int done_cnt = 0;
  int done_edge = -1;

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input bit s, input bit h, input bit c);
    start = s; hold = h; cancel = c;
    model_edge(s, h, c);
    sb.push_back(model_out());
    @(posedge clk);
    edge_n++;
    #1;
    check("cycle", dut_out(), sb.pop_front());
    if (done === 1'b1) begin
      done_cnt++;
      done_edge = edge_n;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit h = 0);
    for (int i = 0; i < n; i++) step(0, h, 0);
  endtask

  int n0;

  initial begin
    sysclr = 1'b1; start = 0; hold = 0; cancel = 0;
    model_reset();
    #1;
    check("reset_out", dut_out(), 32'h0000_7F7F);
    @(negedge clk);
    @(negedge clk);
    sysclr = 1'b0;
    idle(3);

    // Basic countdown
    done_cnt = 0;
    step(1, 0, 0); n0 = edge_n;
    check("seg_s_2", 32'(seg_s), 32'h24);
    check("seg_t_0", 32'(seg_100ms), 32'h40);
    idle(4);
    check("digits_1_9", {sec_bcd, tenth_bcd}, 32'h19);
    idle(36);
    check("digits_1_0", {sec_bcd, tenth_bcd}, 32'h10);
    idle(45);
    check("basic_done_edge", done_edge - n0, 80);
    check("basic_done_cnt", done_cnt, 1);

    // Hold for 13 cycles at 1.5
    done_cnt = 0;
    step(1, 0, 0); n0 = edge_n;
    idle(20);
    check("hold_at_1_5", {sec_bcd, tenth_bcd}, 32'h15);
    idle(13, 1);
    check("hold_still_1_5", {sec_bcd, tenth_bcd}, 32'h15);
    idle(3);
    check("hold_after_release", {sec_bcd, tenth_bcd}, 32'h15);
    idle(65);
    check("hold_done_edge", done_edge - n0, 93);
    check("hold_done_cnt", done_cnt, 1);

    // Retrigger at 0.3
    done_cnt = 0;
    step(1, 0, 0);
    idle(68);
    check("retrig_at_0_3", {sec_bcd, tenth_bcd}, 32'h03);
    step(1, 0, 0); n0 = edge_n;
    check("retrig_reload", {sec_bcd, tenth_bcd}, 32'h20);
    idle(85);
    check("retrig_done_cnt", done_cnt, 1);
    check("retrig_done_edge", done_edge - n0, 80);

    // Cancel at 1.2
    done_cnt = 0;
    step(1, 0, 0);
    idle(32);
    check("cancel_at_1_2", {sec_bcd, tenth_bcd}, 32'h12);
    step(0, 0, 1);
    check("cancel_segs", {seg_s, seg_100ms}, 32'h3FFF);
    idle(100);
    check("cancel_no_done", done_cnt, 0);

    // cancel beats start on the same edge
    step(1, 0, 1);
    check("cancel_start_idle", busy, 0);

    // start on the terminal-tick edge
    done_cnt = 0;
    step(1, 0, 0);
    idle(79);
    step(1, 0, 0);
    check("term_start_busy", busy, 1);
    check("term_start_digits", {sec_bcd, tenth_bcd}, 32'h20);
    check("term_start_no_done", done_cnt, 0);
    step(0, 0, 1);

    // start with hold high: paused at 2.0 until release
    step(1, 1, 0);
    idle(10, 1);
    check("hold_start_busy", busy, 1);
    check("hold_start_digits", {sec_bcd, tenth_bcd}, 32'h20);
    idle(4);
    check("hold_start_first_tick", {sec_bcd, tenth_bcd}, 32'h19);
    step(0, 0, 1);

    // Async reset between edges
    step(1, 0, 0);
    idle(10);
    #2;
    sysclr = 1'b1;
    #1;
    check("async_reset_out", dut_out(), 32'h0000_7F7F);
    model_reset();
    @(negedge clk);
    sysclr = 1'b0;
    idle(6);
    check("post_reset_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
